// File: rtl/mem_responder.sv
// Req/ack memory slave with WAIT_CYCLES wait states and big-endian word/half/byte access.
// Optional macro MEM_RESP_ERR_EN: reject misaligned or out-of-range accesses with err.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);
    // state  | meaning
    // S_IDLE | waiting for req; latches the request on acceptance
    // S_WAIT | counting wait states, inputs ignored
    // S_RESP | performs the access; ack/err/rdata register on the next edge

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   mem_word;
    logic [31:0]   rd_val;
    logic [31:0]   wr_word;
    logic          rej;
    logic          mem_we;

    assign idx      = addr_q[AW+1:2];
    assign mem_word = mem_q[idx];

`ifdef MEM_RESP_ERR_EN
    logic misalign;
    assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                      (((size_q == 2'b00) || (size_q == 2'b11)) && (addr_q[1:0] != 2'b00));
    assign rej = misalign || (addr_q[31:AW+2] != '0);
`else
    // Upper address bits alias onto the array when rejection is disabled.
    logic unused_addr;
    assign unused_addr = ^addr_q[31:AW+2];
    assign rej = 1'b0;
`endif

    // Big-endian lanes: offset 0 is bits [31:24].
    always_comb begin
        rd_val  = mem_word;
        wr_word = mem_word;
        case (size_q)
            2'b01: begin
                if (addr_q[1]) begin
                    rd_val        = {16'h0, mem_word[15:0]};
                    wr_word[15:0] = wdata_q[15:0];
                end else begin
                    rd_val         = {16'h0, mem_word[31:16]};
                    wr_word[31:16] = wdata_q[15:0];
                end
            end
            2'b10: begin
                case (addr_q[1:0])
                    2'd0: begin rd_val = {24'h0, mem_word[31:24]}; wr_word[31:24] = wdata_q[7:0]; end
                    2'd1: begin rd_val = {24'h0, mem_word[23:16]}; wr_word[23:16] = wdata_q[7:0]; end
                    2'd2: begin rd_val = {24'h0, mem_word[15:8]};  wr_word[15:8]  = wdata_q[7:0]; end
                    default: begin rd_val = {24'h0, mem_word[7:0]}; wr_word[7:0] = wdata_q[7:0]; end
                endcase
            end
            default: wr_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_RESP;
            end
            S_RESP: begin
                ack_d   = 1'b1;
                err_d   = rej;
                mem_we  = we_q && !rej;
                rdata_d = (!we_q && !rej) ? rd_val : '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is never reset; reset forces S_IDLE so a pending write cannot commit.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx] <= wr_word;
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != S_IDLE) || ack_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a WAIT_CYCLES=2 instance,
// hand sequences for back-to-back (WAIT_CYCLES=0) and reset-abort.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req, a_we, a_ack, a_busy, a_err;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack, b_busy, b_err;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk_i(clk), .reset_i(rst_n), .req_i(a_req), .we_i(a_we), .size_i(a_size),
        .addr_i(a_addr), .wdata_i(a_wdata), .ack_o(a_ack), .rdata_o(a_rdata),
        .busy_o(a_busy), .err_o(a_err)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk_i(clk), .reset_i(rst_n), .req_i(b_req), .we_i(b_we), .size_i(b_size),
        .addr_i(b_addr), .wdata_i(b_wdata), .ack_o(b_ack), .rdata_o(b_rdata),
        .busy_o(b_busy), .err_o(b_err)
    );

    typedef struct {
        bit        we;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(bit we, bit [1:0] size, bit [31:0] addr, bit [31:0] wdata,
                                bit [31:0] exp_rdata, bit exp_err);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit req, input bit we, input bit [1:0] size,
                         input bit [31:0] addr, input bit [31:0] wdata);
        if (sel) begin
            b_req = req; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = req; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // exp_k: negedges after the accepting edge until ack is seen (WAIT_CYCLES+2).
    task automatic access(input bit sel, input bit we, input bit [1:0] size, input bit [31:0] addr,
                          input bit [31:0] wdata, input int exp_k, input string name,
                          output logic [31:0] rd, output logic er);
        int  k;
        bit  got;
        bit  side_ok;
        logic ack_s, busy_s, err_s;
        logic [31:0] rdata_s;
        @(negedge clk);
        drive(sel, 1'b1, we, size, addr, wdata);
        @(posedge clk);
        got = 1'b0; side_ok = 1'b1; k = 0; rd = '0; er = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) drive(sel, 1'b0, we, size, addr, wdata);
            ack_s   = sel ? b_ack   : a_ack;
            busy_s  = sel ? b_busy  : a_busy;
            err_s   = sel ? b_err   : a_err;
            rdata_s = sel ? b_rdata : a_rdata;
            if (ack_s === 1'b1) begin
                got = 1'b1; rd = rdata_s; er = err_s;
                if (busy_s !== 1'b1) side_ok = 1'b0;
            end else if (busy_s !== 1'b1 || err_s !== 1'b0 || rdata_s !== 32'h0) begin
                side_ok = 1'b0;
            end
        end
        check32({name, " latency"}, 32'(k), 32'(exp_k));
        check32({name, " busy/idle outputs"}, {31'h0, side_ok}, 32'h1);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, 2'b00, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        vecs[1]  = mk(0, 2'b00, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1, 2'b00, 32'h20,  32'h11223344, 32'h0,        1'b0);
        vecs[3]  = mk(1, 2'b10, 32'h21,  32'hFFFFFFAA, 32'h0,        1'b0);
        vecs[4]  = mk(0, 2'b00, 32'h20,  32'h0,        32'h11AA3344, 1'b0);
        vecs[5]  = mk(0, 2'b10, 32'h23,  32'h0,        32'h00000044, 1'b0);
        vecs[6]  = mk(0, 2'b01, 32'h22,  32'h0,        32'h00003344, 1'b0);
        vecs[7]  = mk(1, 2'b01, 32'h20,  32'hFFFFBEEF, 32'h0,        1'b0);
        vecs[8]  = mk(0, 2'b00, 32'h20,  32'h0,        32'hBEEF3344, 1'b0);
        vecs[9]  = mk(0, 2'b10, 32'h20,  32'h0,        32'h000000BE, 1'b0);
        vecs[10] = mk(0, 2'b10, 32'h22,  32'h0,        32'h00000033, 1'b0);
        vecs[11] = mk(1, 2'b00, 32'h00,  32'hCAFEF00D, 32'h0,        1'b0);
        vecs[12] = mk(0, 2'b11, 32'h00,  32'h0,        32'hCAFEF00D, 1'b0);
        vecs[13] = mk(1, 2'b11, 32'h04,  32'h01020304, 32'h0,        1'b0);
        vecs[14] = mk(0, 2'b00, 32'h04,  32'h0,        32'h01020304, 1'b0);
        vecs[15] = mk(0, 2'b00, 32'h02,  32'h0,        ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN);
        vecs[16] = mk(0, 2'b00, 32'h400, 32'h0,        ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN);
        vecs[17] = mk(1, 2'b00, 32'h404, 32'hFFFFFFFF, 32'h0,        ERR_EN);
        vecs[18] = mk(0, 2'b00, 32'h04,  32'h0,        ERR_EN ? 32'h01020304 : 32'hFFFFFFFF, 1'b0);
        vecs[19] = mk(0, 2'b01, 32'h21,  32'h0,        ERR_EN ? 32'h0 : 32'h0000BEEF, ERR_EN);
        vecs[20] = mk(1, 2'b01, 32'h23,  32'h00009999, 32'h0,        ERR_EN);
        vecs[21] = mk(0, 2'b00, 32'h20,  32'h0,        ERR_EN ? 32'hBEEF3344 : 32'hBEEF9999, 1'b0);
        vecs[22] = mk(1, 2'b00, 32'h30,  32'h12345678, 32'h0,        1'b0);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check32("reset a outputs", {a_ack, a_busy, a_err}, 32'h0);
        check32("reset a rdata", a_rdata, 32'h0);
        check32("reset b outputs", {b_ack, b_busy, b_err}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            access(1'b0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, 4,
                   $sformatf("vec%0d", i), rd, er);
            check32($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check32($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
        end

        // Zero wait states, req held for four cycles: two back-to-back writes.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h8, 32'h0BADF00D);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check32($sformatf("b2b cycle%0d ack", c), {31'h0, b_ack}, {31'h0, (c == 2 || c == 4)});
            check32($sformatf("b2b cycle%0d busy", c), {31'h0, b_busy}, {31'h0, (c <= 4)});
            if (c == 4) b_req = 1'b0;
        end
        access(1'b1, 1'b0, 2'b00, 32'h8, 32'h0, 2, "b read", rd, er);
        check32("b read rdata", rd, 32'h0BADF00D);
        check32("b read err", {31'h0, er}, 32'h0);

        // Reset during WAIT aborts a byte write to 0x30.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h30, 32'h00000055);
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0;
        check32("abort busy before reset", {31'h0, a_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check32("abort ack/busy/err", {a_ack, a_busy, a_err}, 32'h0);
        check32("abort rdata", a_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b0, 2'b00, 32'h30, 32'h0, 4, "abort readback", rd, er);
        check32("abort readback rdata", rd, 32'h12345678);
        check32("abort readback err", {31'h0, er}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle CPU's data/instruction memory port. It replaces the fixed-latency memory with a req/ack slave that has a programmable number of wait states. It supports word, halfword and byte reads and writes in big-endian byte order. It sits between the CPU datapath (address mux, store-size logic) and a word-organised internal RAM array.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of 2.
WAIT_CYCLES, 2, wait states between request acceptance and ack; 0 is legal.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = write, 0 = read; latched at acceptance
size  input  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as word)
addr  input  32  byte address; latched at acceptance
wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
ack  output  1  one-cycle completion pulse
rdata  output  32  read data, zero-extended and right-justified; valid only while ack=1
busy  output  1  high from the cycle after acceptance until ack, inclusive
err  output  1  pulses together with ack when the access was rejected (feature-dependent)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, busy=0, err=0, rdata=0, wait counter=0. RAM contents are not cleared.
- Reset asserted mid-transaction aborts it. A write still in WAIT is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1, latch we/size/addr/wdata, load counter=WAIT_CYCLES, and go to WAIT (or to RESP if WAIT_CYCLES=0).
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1. req and all inputs are ignored.
- RESP (one cycle): perform the access, assert ack=1, then return to IDLE.
- Latency: req sampled high on edge N gives ack high during the cycle after edge N+WAIT_CYCLES+1.
- A req still high in IDLE after ack is a new request. The requester must drop req in the ack cycle, so the minimum issue interval is WAIT_CYCLES+2 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte offset = addr[1:0], big-endian: offset 0 = bits [31:24].
- Reads:
  - word: the whole word.
  - half: offset 0 gives [31:16], offset 2 gives [15:0].
  - byte: the lane selected by offset.
  - Result is zero-extended into rdata. rdata returns to 0 when ack=0.
- Writes are read-modify-write of the addressed lanes only; other lanes are preserved. rdata=0 on write acks.
- A write is committed at the RESP edge, so a read accepted in the following IDLE returns the new data.
- size=11 behaves exactly as a word access.

Optional Feature:
Macro MEM_RESP_ERR_EN.
- Defined:
  - Access is rejected if the alignment is wrong (half with addr[0]=1, word with addr[1:0]!=0).
  - Access is rejected if addr >= 4*DEPTH_WORDS.
  - A rejected access still takes the full latency, then ack=1 with err=1 and rdata=0, and the RAM is untouched.
- Not defined:
  - err is tied to 0.
  - Misaligned low bits are ignored: half uses addr[1] only, word ignores addr[1:0].
  - Addresses wrap modulo 4*DEPTH_WORDS.

Test Plan:
1. Word write then read, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10, then read 0x10 -> each ack arrives 3 cycles after req; read rdata=0xDEADBEEF, err=0.
2. Byte merge: word 0x11223344 at 0x20, byte write 0xAA to 0x21, word read 0x20 -> 0x11AA3344. Byte read 0x23 -> 0x00000044.
3. Halfword: half read 0x22 of 0x11AA3344 -> 0x00003344. Half write 0xBEEF to 0x20 -> word 0xBEEF3344.
4. WAIT_CYCLES=0 back-to-back: req held high 4 cycles -> acks on cycles 2 and 4, with busy high in the cycles between.
5. Reset mid-write: accept a write of 0x55 to 0x30, pull reset low during WAIT -> ack/busy are 0 immediately; a later read of 0x30 returns the old value.
6. With MEM_RESP_ERR_EN: word read 0x02 -> ack=1, err=1, rdata=0. Without it: the same read returns word 0x00, err=0. Read 0x400 (DEPTH 256) -> err=1 with the macro, aliases word 0 without it.
